// File: rtl/bp_me_nonsynth_cfg_responder.sv
// Config-register responder for the uncached io_cmd/io_resp stream of the CCE mmio cfg loader.
// Build option: `define BP_CFG_RESP_LATENCY_EN adds a stall of stall_p cycles before each response.
//
// state  | meaning
// eReady | idle, accepts a command when io_cmd_v_i is high
// eStall | response computed, waiting for the stall counter (BP_CFG_RESP_LATENCY_EN only)
// eResp  | response presented, held until io_resp_ready_i
module bp_me_nonsynth_cfg_responder
  #(parameter int paddr_width_p   = 40
    , parameter int data_width_p    = 128
    , parameter int payload_width_p = 16
    , parameter int reg_els_p       = 16
    , parameter logic [paddr_width_p-1:0] base_addr_p = 'h20_0000
    , parameter int stall_p         = 3
    , localparam int cce_mem_msg_width_lp = data_width_p + payload_width_p + 3 + paddr_width_p + 4
    )
   (input  logic                              clk_i
    , input  logic                            reset_i
    , input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i
    , input  logic                            io_cmd_v_i
    , output logic                            io_cmd_yumi_o
    , output logic [cce_mem_msg_width_lp-1:0] io_resp_o
    , output logic                            io_resp_v_o
    , input  logic                            io_resp_ready_i
    , output logic                            freeze_o
    , output logic [reg_els_p*64-1:0]         cfg_regs_o
    , output logic                            err_o
    );

    localparam int lg_reg_els_lp = $clog2(reg_els_p);
    localparam logic [paddr_width_p:0] win_end_lp =
        {1'b0, base_addr_p} + (paddr_width_p+1)'(reg_els_p*8);

    if (reg_els_p < 2 || (reg_els_p & (reg_els_p-1)) != 0 || stall_p < 0) begin : g_bad_params
        $error("bp_me_nonsynth_cfg_responder: reg_els_p must be a power of 2 >= 2, stall_p >= 0");
    end

    localparam logic [3:0] e_cce_mem_rd    = 4'd0;
    localparam logic [3:0] e_cce_mem_wr    = 4'd1;
    localparam logic [3:0] e_cce_mem_uc_rd = 4'd2;
    localparam logic [3:0] e_cce_mem_uc_wr = 4'd3;

    typedef struct packed {
        logic [payload_width_p-1:0] payload;
        logic [2:0]                 size;
        logic [paddr_width_p-1:0]   addr;
        logic [3:0]                 msg_type;
    } header_s;

    typedef struct packed {
        logic [data_width_p-1:0] data;
        header_s                 header;
    } msg_s;

`ifdef BP_CFG_RESP_LATENCY_EN
    typedef enum logic [1:0] {eReady, eStall, eResp} state_e;
    localparam int cnt_width_lp = (stall_p > 0) ? $clog2(stall_p+1) : 1;
    logic [cnt_width_lp-1:0] cnt_r, cnt_n;
`else
    typedef enum logic {eReady, eResp} state_e;
`endif

    state_e state_r, state_n;
    msg_s   cmd_li, resp_r, cmd_resp;
    logic   [63:0] regs_r [reg_els_p];
    logic   err_r;
    logic   yumi, resp_v;
    logic   in_window, is_rd, is_wr, is_cached, cmd_err, wr_en;
    logic   [lg_reg_els_lp-1:0] idx;
    logic   unused_cmd_data;

    assign cmd_li          = io_cmd_i;
    assign unused_cmd_data = ^cmd_li.data[data_width_p-1:64];

    // Decode and response formation for the command at the input; used only on yumi.
    always_comb begin
        in_window = (cmd_li.header.addr >= base_addr_p)
                    && ({1'b0, cmd_li.header.addr} < win_end_lp);
        idx       = cmd_li.header.addr[3 +: lg_reg_els_lp];
        is_rd     = (cmd_li.header.msg_type == e_cce_mem_rd)
                    || (cmd_li.header.msg_type == e_cce_mem_uc_rd);
        is_wr     = (cmd_li.header.msg_type == e_cce_mem_wr)
                    || (cmd_li.header.msg_type == e_cce_mem_uc_wr);
        is_cached = (cmd_li.header.msg_type == e_cce_mem_rd)
                    || (cmd_li.header.msg_type == e_cce_mem_wr);
        cmd_err   = ~in_window | is_cached | ~(is_rd | is_wr);
        wr_en     = yumi & is_wr & in_window;

        cmd_resp        = '0;
        cmd_resp.header = cmd_li.header;
        if (is_rd) begin
            if (in_window)
                cmd_resp.data = data_width_p'(regs_r[idx]);
            else
                cmd_resp.data = '1;
        end
    end

    always_comb begin
        state_n = state_r;
        yumi    = 1'b0;
        resp_v  = 1'b0;
`ifdef BP_CFG_RESP_LATENCY_EN
        cnt_n   = cnt_r;
`endif
        case (state_r)
            eReady: begin
                yumi = io_cmd_v_i;
                if (yumi) begin
`ifdef BP_CFG_RESP_LATENCY_EN
                    cnt_n = cnt_width_lp'(stall_p);
                    if (stall_p == 0)
                        state_n = eResp;
                    else
                        state_n = eStall;
`else
                    state_n = eResp;
`endif
                end
            end
`ifdef BP_CFG_RESP_LATENCY_EN
            eStall: begin
                cnt_n = cnt_r - 1'b1;
                if (cnt_n == '0)
                    state_n = eResp;
            end
`endif
            eResp: begin
                resp_v = 1'b1;
                if (io_resp_ready_i) begin
`ifdef BP_CFG_RESP_LATENCY_EN
                    state_n = eReady;
`else
                    // Back-to-back: the slot frees this cycle, so the next command can take it.
                    yumi    = io_cmd_v_i;
                    state_n = yumi ? eResp : eReady;
`endif
                end
            end
            default: state_n = eReady;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eReady;
            resp_r  <= '0;
            err_r   <= 1'b0;
`ifdef BP_CFG_RESP_LATENCY_EN
            cnt_r   <= '0;
`endif
            for (int i = 0; i < reg_els_p; i++)
                regs_r[i] <= (i == 0) ? 64'h1 : 64'h0;
        end
        else begin
            state_r <= state_n;
`ifdef BP_CFG_RESP_LATENCY_EN
            cnt_r   <= cnt_n;
`endif
            if (yumi) begin
                resp_r <= cmd_resp;
                if (cmd_err)
                    err_r <= 1'b1;
            end
            if (wr_en)
                regs_r[idx] <= cmd_li.data[63:0];
        end
    end

    assign io_cmd_yumi_o = yumi;
    assign io_resp_v_o   = resp_v;
    assign io_resp_o     = resp_r;
    assign err_o         = err_r;
    assign freeze_o      = regs_r[0][0];

    for (genvar i = 0; i < reg_els_p; i++) begin : g_cfg_out
        assign cfg_regs_o[64*i +: 64] = regs_r[i];
    end

endmodule
